// File: rtl/alu_instruction_issuer.sv
// -----------------------------------------------------------------------------
// alu_instruction_issuer
//
// Stores a small program of 26-bit ALU/register-file words and replays it one
// word at a time. Each issued word is followed by RESULT_WAIT cycles of waiting.
// On the last waiting cycle the ALU result and flags are captured, and any
// overflow is counted. The run can be aborted with halt. The stored program is
// kept after a run, so start replays it.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   load_valid/load_word    program word offered ([25:24] op, [23:0] rf field)
//   load_ready              word accepted this cycle when high with load_valid
//   clear                   empty the program (IDLE only)
//   start / halt            begin a run / abort the run in progress
//   instruction/instr_valid word to the datapath, new-this-cycle strobe
//   alu_out/alu_overflow/alu_c_out  ALU result and flags
//   busy / done             run in progress / one-cycle completion pulse
//   pc / count              current or last-issued entry / stored word count
//   last_out / last_flags   last captured result / {overflow, carry}
//   ovf_count               overflows seen in the current or last run
// -----------------------------------------------------------------------------
module alu_instruction_issuer #(
  parameter int DEPTH       = 16,
  parameter int RESULT_WAIT = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [25:0]   load_word,
  output logic          load_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          halt,
  output logic [25:0]   instruction,
  output logic          instr_valid,
  input  logic [15:0]   alu_out,
  input  logic          alu_overflow,
  input  logic          alu_c_out,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count,
  output logic [15:0]   last_out,
  output logic [1:0]    last_flags,
  output logic [AW:0]   ovf_count
);

  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
  localparam logic [2:0]  WAIT_END = 3'(RESULT_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [25:0]   mem [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [25:0]   instr_q, instr_d;
  logic [2:0]    wait_q, wait_d;
  logic [15:0]   last_out_q, last_out_d;
  logic [1:0]    last_flags_q, last_flags_d;
  logic [AW:0]   ovf_q, ovf_d;

  logic load_fire, start_ok, wait_last, at_end, capture;

  assign load_ready = (state_q == IDLE) && (count_q < FULL) && !start && !clear;
  assign load_fire  = load_valid && load_ready;
  assign start_ok   = (state_q == IDLE) && start && !clear && (count_q != '0);
  assign wait_last  = (state_q == WAIT) && (wait_q == WAIT_END);
  assign at_end     = ({1'b0, pc_q} == count_q - 1'b1);
  // halt beats the result capture when both land on the same cycle
  assign capture    = wait_last && !halt;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_ok) state_d = ISSUE;
      ISSUE: state_d = halt ? IDLE : WAIT;
      WAIT: begin
        if (halt)           state_d = IDLE;
        else if (wait_last) state_d = at_end ? DONE : ISSUE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath next
  always_comb begin
    count_d      = count_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    wait_d       = wait_q;
    last_out_d   = last_out_q;
    last_flags_d = last_flags_q;
    ovf_d        = ovf_q;

    if (load_fire) count_d = count_q + 1'b1;
    if (state_q == IDLE && clear) count_d = '0;

    if (start_ok) begin
      pc_d  = '0;
      ovf_d = '0;
    end

    if (state_q == ISSUE) wait_d = '0;
    if (state_q == WAIT)  wait_d = wait_q + 3'd1;

    if (capture) begin
      last_out_d   = alu_out;
      last_flags_d = {alu_overflow, alu_c_out};
      ovf_d        = ovf_q + {{AW{1'b0}}, alu_overflow};
      if (!at_end) pc_d = pc_q + 1'b1;
    end

    // The word is registered on entry to ISSUE, so it is stable for the
    // whole ISSUE cycle and simply holds afterwards.
    if (state_d == ISSUE) instr_d = mem[pc_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      pc_q         <= '0;
      instr_q      <= '0;
      wait_q       <= '0;
      last_out_q   <= '0;
      last_flags_q <= '0;
      ovf_q        <= '0;
    end else begin
      count_q      <= count_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      wait_q       <= wait_d;
      last_out_q   <= last_out_d;
      last_flags_q <= last_flags_d;
      ovf_q        <= ovf_d;
    end
  end

  // NOTE: program memory has no reset; count=0 makes stale entries unreachable,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (load_fire) mem[count_q[AW-1:0]] <= load_word;
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    instr_valid = (state_q == ISSUE);
    busy        = (state_q == ISSUE) || (state_q == WAIT);
    done        = (state_q == DONE);
    instruction = instr_q;
    pc          = pc_q;
    count       = count_q;
    last_out    = last_out_q;
    last_flags  = last_flags_q;
    ovf_count   = ovf_q;
  end

endmodule

// File: tb/tb_alu_instruction_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_instruction_issuer
//
// Directed sequence of loads, runs, halts, clears and resets, with random ALU
// results. Expected values come from a program queue and arithmetic on the
// cycle index relative to start (issue every RESULT_WAIT+1 cycles).
// -----------------------------------------------------------------------------
module tb_alu_instruction_issuer;

  localparam int DEPTH       = 16;
  localparam int RESULT_WAIT = 1;
  localparam int AW          = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset, load_valid, clear, start, halt, alu_overflow, alu_c_out;
  logic [25:0]   load_word;
  logic [15:0]   alu_out;
  logic          load_ready, instr_valid, busy, done;
  logic [25:0]   instruction;
  logic [AW-1:0] pc;
  logic [AW:0]   count, ovf_count;
  logic [15:0]   last_out;
  logic [1:0]    last_flags;

  alu_instruction_issuer #(.DEPTH(DEPTH), .RESULT_WAIT(RESULT_WAIT)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_word(load_word),
    .load_ready(load_ready), .clear(clear), .start(start), .halt(halt),
    .instruction(instruction), .instr_valid(instr_valid), .alu_out(alu_out),
    .alu_overflow(alu_overflow), .alu_c_out(alu_c_out), .busy(busy), .done(done),
    .pc(pc), .count(count), .last_out(last_out), .last_flags(last_flags),
    .ovf_count(ovf_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [25:0] prog[$];
  logic [15:0] m_last_out;
  logic [1:0]  m_last_flags;
  int          m_ovf;
  logic [25:0] m_instr;

  // optional forcing of ALU results for a run
  bit          use_plan;
  bit [15:0]   ovf_plan;
  bit          force_final;
  logic [15:0] final_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prog.delete();
    m_last_out   = '0;
    m_last_flags = '0;
    m_ovf        = 0;
    m_instr      = '0;
  endtask

  task automatic check_reset_vals(input string ctx);
    check({ctx, "_instruction"}, 32'(instruction), 0);
    check({ctx, "_instr_valid"}, 32'(instr_valid), 0);
    check({ctx, "_busy"},        32'(busy), 0);
    check({ctx, "_done"},        32'(done), 0);
    check({ctx, "_pc"},          32'(pc), 0);
    check({ctx, "_count"},       32'(count), 0);
    check({ctx, "_last_out"},    32'(last_out), 0);
    check({ctx, "_last_flags"},  32'(last_flags), 0);
    check({ctx, "_ovf_count"},   32'(ovf_count), 0);
  endtask

  task automatic load_one(input logic [25:0] w);
    @(negedge clock);
    load_valid = 1'b1;
    load_word  = w;
    #1 check("load_ready", 32'(load_ready), 32'(prog.size() < DEPTH));
    if (prog.size() < DEPTH) prog.push_back(w);
  endtask

  task automatic end_load();
    @(negedge clock);
    load_valid = 1'b0;
    check("count_after_load", 32'(count), prog.size());
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    #1 check("ready_during_clear", 32'(load_ready), 0);
    @(negedge clock);
    clear = 1'b0;
    prog.delete();
    check("count_after_clear", 32'(count), 0);
  endtask

  // Runs the stored program; halt_k>0 asserts halt during cycle halt_k after start.
  task automatic run_prog(input int halt_k);
    int n, per, total, last_k, idx, j;
    bit ov, co, exp_valid;
    logic [15:0] ao;
    n      = prog.size();
    per    = RESULT_WAIT + 1;
    total  = n * per;
    last_k = (halt_k > 0) ? halt_k + 1 : total + 2;
    idx    = 0;
    @(negedge clock);
    start = 1'b1;
    #1 check("ready_at_start", 32'(load_ready), 0);
    m_ovf = 0;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clock);
      start = 1'b0;
      halt  = 1'b0;
      if (halt_k > 0 && k == halt_k + 1) begin
        check("halt_busy",  32'(busy), 0);
        check("halt_done",  32'(done), 0);
        check("halt_valid", 32'(instr_valid), 0);
        check("halt_pc",    32'(pc), idx);
      end else begin
        exp_valid = (k <= total) && ((k - 1) % per == 0);
        if (k <= total) idx = (k - 1) / per;
        if (exp_valid) m_instr = prog[idx];
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        check("busy",        32'(busy), 32'(k <= total));
        check("done",        32'(done), 32'(k == total + 1));
        check("pc",          32'(pc), idx);
      end
      check("instruction", 32'(instruction), 32'(m_instr));
      check("last_out",    32'(last_out), 32'(m_last_out));
      check("last_flags",  32'(last_flags), 32'(m_last_flags));
      check("ovf_count",   32'(ovf_count), m_ovf);

      ao = 16'($urandom());
      ov = 1'($urandom());
      co = 1'($urandom());
      if (k <= total && k % per == 0) begin
        j = k / per - 1;
        if (use_plan) ov = ovf_plan[j];
        if (force_final && j == n - 1) ao = final_out;
        if (k != halt_k) begin
          m_last_out   = ao;
          m_last_flags = {ov, co};
          m_ovf        = m_ovf + int'(ov);
        end
      end
      alu_out      = ao;
      alu_overflow = ov;
      alu_c_out    = co;
      if (k == halt_k) halt = 1'b1;
    end
    check("count_retained", 32'(count), n);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_word = '0; clear = 1'b0;
    start = 1'b0; halt = 1'b0; alu_out = '0; alu_overflow = 1'b0; alu_c_out = 1'b0;
    use_plan = 1'b0; ovf_plan = '0; force_final = 1'b0; final_out = '0;
    model_reset();

    // reset state
    repeat (2) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;
    #1 check("ready_after_reset", 32'(load_ready), 1);

    // three-word program, issue timing 1/3/5, done at 7
    load_one(26'h1000001);
    load_one(26'h2ABCDEF);
    load_one(26'h0123456);
    end_load();
    run_prog(0);

    // rerun: overflow on 1st and 3rd results, final result 0xBEEF
    use_plan = 1'b1; ovf_plan = 16'b101; force_final = 1'b1; final_out = 16'hBEEF;
    run_prog(0);
    check("ovf_two", 32'(ovf_count), 2);
    check("last_beef", 32'(last_out), 32'h0000BEEF);
    use_plan = 1'b0; force_final = 1'b0;

    // clear, then start with an empty program
    do_clear();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("empty_start_valid", 32'(instr_valid), 0);
    check("empty_start_busy",  32'(busy), 0);
    @(negedge clock);
    check("empty_start_valid2", 32'(instr_valid), 0);

    // start coincident with clear
    for (int i = 0; i < 4; i++) load_one(26'($urandom()));
    end_load();
    @(negedge clock); start = 1'b1; clear = 1'b1;
    @(negedge clock); start = 1'b0; clear = 1'b0;
    prog.delete();
    check("sc_valid", 32'(instr_valid), 0);
    check("sc_busy",  32'(busy), 0);
    check("sc_count", 32'(count), 0);
    @(negedge clock);
    check("sc_valid2", 32'(instr_valid), 0);

    // four words, halt in WAIT of the 2nd, then rerun to completion
    for (int i = 0; i < 4; i++) load_one(26'($urandom()));
    end_load();
    run_prog(2 * (RESULT_WAIT + 1));
    run_prog(0);

    // fill to capacity and one more offer, then run the full program
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) load_one(26'($urandom()));
    end_load();
    check("full_count", 32'(count), DEPTH);
    run_prog(0);

    // reset during ISSUE aborts the run; later start is ignored
    do_clear();
    for (int i = 0; i < 3; i++) load_one(26'($urandom()));
    end_load();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("pre_reset_issue", 32'(instr_valid), 1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("midrun_reset");
    reset = 1'b0;
    model_reset();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("post_reset_valid", 32'(instr_valid), 0);
    check("post_reset_busy",  32'(busy), 0);
    @(negedge clock);
    check("post_reset_valid2", 32'(instr_valid), 0);
    check("post_reset_done",   32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_instruction_issuer.md
ALU_INSTRUCTION_ISSUER -- requirements
Module: alu_instruction_issuer

Interface
REQ-001 The block SHALL use a single clock named clock and a synchronous, active-high reset named reset; no other clock or reset exists.
REQ-002 Parameter DEPTH, 16: number of program entries, a power of two.
REQ-003 Parameter RESULT_WAIT, 1: cycles between instr_valid and sampling of the ALU result, range 1..7.
REQ-004 Port clock  input  1  rising-edge clock.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port load_valid  input  1  program word offered.
REQ-007 Port load_word  input  26  program word: [25:24] op_code, [23:0] register-file field.
REQ-008 Port load_ready  output  1  program word accepted this cycle when high with load_valid.
REQ-009 Port clear  input  1  empty the program (IDLE only).
REQ-010 Port start  input  1  begin issuing the stored program.
REQ-011 Port halt  input  1  abort the run in progress.
REQ-012 Port instruction  output  26  word driven to the ALU/register-file datapath.
REQ-013 Port instr_valid  output  1  instruction is new this cycle.
REQ-014 Port alu_out  input  16  ALU result.
REQ-015 Port alu_overflow  input  1  ALU overflow flag.
REQ-016 Port alu_c_out  input  1  ALU carry-out.
REQ-017 Port busy  output  1  run in progress.
REQ-018 Port done  output  1  one-cycle pulse on completion.
REQ-019 Port pc  output  log2(DEPTH)  index of the current or last-issued entry.
REQ-020 Port count  output  log2(DEPTH)+1  number of stored words.
REQ-021 Port last_out  output  16  last captured alu_out.
REQ-022 Port last_flags  output  2  last captured {alu_overflow, alu_c_out}.
REQ-023 Port ovf_count  output  log2(DEPTH)+1  overflows seen in the current or last run.

Function
REQ-024 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-025 load_ready SHALL equal (state==IDLE && count<DEPTH && !start && !clear).
REQ-026 Each accepted word SHALL be written to entry count, and count SHALL increment by 1.
REQ-027 When full (count==DEPTH), load_ready SHALL be 0 and load_valid SHALL be ignored.
REQ-028 clear in IDLE SHALL set count to 0 next cycle; clear outside IDLE SHALL be ignored; stored words SHALL be unaffected.
REQ-029 start in IDLE with count>0 and clear=0 SHALL set pc=0, ovf_count=0 and busy=1, then go to ISSUE; start with count==0, start with clear=1, and start outside IDLE SHALL be ignored.
REQ-030 In ISSUE the block SHALL drive instruction=entry[pc] with instr_valid=1 for exactly one cycle, then go to WAIT.
REQ-031 WAIT SHALL last RESULT_WAIT cycles; on its final cycle the block SHALL register alu_out into last_out and {alu_overflow, alu_c_out} into last_flags, and SHALL increment ovf_count if alu_overflow=1.
REQ-032 After WAIT, if pc==count-1 the FSM SHALL go to DONE; otherwise pc SHALL increment and the FSM SHALL go to ISSUE.
REQ-033 Issue rate SHALL therefore be one instruction per RESULT_WAIT+1 cycles.
REQ-034 DONE SHALL assert done=1 for one cycle, deassert busy, and return to IDLE; program contents and count SHALL be retained so that start reruns the program.
REQ-035 instruction SHALL hold its last value while instr_valid=0.
REQ-036 halt in ISSUE or WAIT SHALL return the FSM to IDLE next cycle with busy=0 and done=0, and SHALL NOT capture the in-flight result; pc and ovf_count SHALL hold their values.
REQ-037 halt in IDLE or DONE SHALL have no effect.
REQ-038 If halt and the final-WAIT capture coincide, halt SHALL win and no capture SHALL occur.

Reset
REQ-039 reset SHALL take priority over all inputs and force state=IDLE, instruction=0, instr_valid=0, busy=0, done=0, pc=0, count=0, last_out=0, last_flags=0, ovf_count=0.
REQ-040 Program memory contents need not be cleared, but SHALL be unreadable until reloaded because count=0.
REQ-041 reset asserted mid-run SHALL abort the run with no done pulse.

Verification
REQ-042 Load 3 words (0x1000001, 0x2ABCDEF, 0x0123456), then start -> instr_valid pulses at cycles 1, 3 and 5 after start carrying those words in order; done pulses at cycle 7; count=3 is retained.
REQ-043 Load 16 words -> load_ready=0 after the 16th; a 17th load_valid is not accepted and count=16.
REQ-044 Run with alu_overflow=1 on the 1st and 3rd results and alu_out=0xBEEF on the last -> ovf_count=2, last_out=0xBEEF, and last_flags equals the final flags.
REQ-045 halt during WAIT of the 2nd instruction of 4 -> busy=0 next cycle, no done pulse, pc=1, last_out holds the 1st result.
REQ-046 start with count=0, and start coincident with clear -> no instr_valid and busy stays 0; clear alone -> count=0.
REQ-047 reset asserted during ISSUE -> all outputs at their reset values next cycle, and a following start is ignored because count=0.
